// File: rtl/uart_receive_param.sv
// rtl/uart_receive_param.sv - parametrised UART receiver with 3-sample majority vote
// Reports parity, framing, break and overrun status alongside each received word.
module uart_receive_param #(
  parameter int CLOCK_SPEED = 100_000_000,
  parameter int BAUD_RATE   = 2_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 readData,
  output logic                 ready,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 breakDet,
  output logic                 overrun
);

  localparam int DIV_RAW = CLOCK_SPEED / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BI_W    = $clog2(DATA_BITS);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_V0     = SC_W'(M - 1);
  localparam logic [SC_W-1:0]  SC_V1     = SC_W'(M);
  localparam logic [SC_W-1:0]  SC_VOTE   = SC_W'(M + 1);
  localparam logic [BI_W-1:0]  BI_LAST   = BI_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             PAR_EN    = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic [SC_W-1:0]      sc;
  logic [BI_W-1:0]      bit_idx;
  logic                 stop_idx;
  logic                 v0, v1;
  logic [DATA_BITS-1:0] shreg;
  logic                 p_err, f_err, all_zero;

  logic tick, vote, par_x, frame_done;

  assign tick  = (div_cnt == DIV_LAST);
  assign vote  = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign par_x = (^shreg) ^ vote;
  // The frame completes at the last stop-bit vote so the next start edge is caught early.
  assign frame_done = tick && (state == S_STOP) && (sc == SC_VOTE) && (stop_idx == STOP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      div_cnt   <= '0;
      state     <= S_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      shreg     <= '0;
      p_err     <= 1'b0;
      f_err     <= 1'b0;
      all_zero  <= 1'b0;
      ready     <= 1'b0;
      dataOut   <= '0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      breakDet  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (tick) begin
        if (state == S_IDLE) begin
          if (!rxs) begin
            state    <= S_START;
            sc       <= '0;
            p_err    <= 1'b0;
            f_err    <= 1'b0;
            all_zero <= 1'b1;
          end
        end else begin
          sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
          if (sc == SC_V0) v0 <= rxs;
          if (sc == SC_V1) v1 <= rxs;
          if (sc == SC_VOTE && vote && state != S_START) all_zero <= 1'b0;

          case (state)
            S_START: begin
              if (sc == SC_VOTE && vote) begin
                state <= S_IDLE;
              end else if (sc == SC_LAST) begin
                state   <= S_DATA;
                bit_idx <= '0;
              end
            end
            S_DATA: begin
              if (sc == SC_VOTE) shreg[bit_idx] <= vote;
              if (sc == SC_LAST) begin
                if (bit_idx == BI_LAST) begin
                  state    <= PAR_EN ? S_PARITY : S_STOP;
                  stop_idx <= 1'b0;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end
            end
            S_PARITY: begin
              if (sc == SC_VOTE) p_err <= PAR_ODD ? ~par_x : par_x;
              if (sc == SC_LAST) state <= S_STOP;
            end
            S_STOP: begin
              if (sc == SC_VOTE) begin
                if (!vote) f_err <= 1'b1;
                if (stop_idx == STOP_LAST) state <= S_IDLE;
              end
              if (sc == SC_LAST) stop_idx <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end

      if (frame_done) begin
        if (!ready || readData) begin
          dataOut   <= shreg;
          parityErr <= PAR_EN & p_err;
          frameErr  <= f_err | ~vote;
          breakDet  <= all_zero & ~vote;
          ready     <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (readData) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive_param.sv
// tb/tb_uart_receive_param.sv - scoreboard bench for uart_receive_param
// Three instances: 8N1, 8E1 and 5O2, all with one tick per clock.
module tb_uart_receive_param;

  localparam int CS = 16_000_000;
  localparam int BR = 1_000_000;
  localparam int OS = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] rd = 3'b000;
  logic [2:0] rdy, perr, ferr, brk, ovr;
  logic [7:0] dout_a, dout_b;
  logic [4:0] dout_c;
  logic [8:0] dout [3];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t0     = 0;
  int lat    = 0;
  int rise_cyc [3];
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receive_param #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .OVERSAMPLE(OS),
                       .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx[0]), .readData(rd[0]), .ready(rdy[0]),
    .dataOut(dout_a), .parityErr(perr[0]), .frameErr(ferr[0]),
    .breakDet(brk[0]), .overrun(ovr[0]));

  uart_receive_param #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .OVERSAMPLE(OS),
                       .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .rx(rx[1]), .readData(rd[1]), .ready(rdy[1]),
    .dataOut(dout_b), .parityErr(perr[1]), .frameErr(ferr[1]),
    .breakDet(brk[1]), .overrun(ovr[1]));

  uart_receive_param #(.CLOCK_SPEED(CS), .BAUD_RATE(BR), .OVERSAMPLE(OS),
                       .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .rx(rx[2]), .readData(rd[2]), .ready(rdy[2]),
    .dataOut(dout_c), .parityErr(perr[2]), .frameErr(ferr[2]),
    .breakDet(brk[2]), .overrun(ovr[2]));

  assign dout[0] = {1'b0, dout_a};
  assign dout[1] = {1'b0, dout_b};
  assign dout[2] = {4'b0, dout_c};

  function automatic int cfg_db(input int d);
    return (d == 2) ? 5 : 8;
  endfunction
  function automatic int cfg_par(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction
  function automatic int cfg_sb(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Line levels of one frame, LSB first: start, data, optional parity, stop bits.
  function automatic logic [15:0] build(input int d, input logic [8:0] data,
                                        input bit bad, output int n);
    logic [15:0] s = '1;
    logic x = 1'b0;
    int k = 0;
    s[k] = 1'b0; k++;
    for (int i = 0; i < cfg_db(d); i++) begin
      s[k] = data[i]; x ^= data[i]; k++;
    end
    if (cfg_par(d) != 0) begin
      s[k] = ((cfg_par(d) == 1) ? ~x : x) ^ bad; k++;
    end
    for (int i = 0; i < cfg_sb(d); i++) begin
      s[k] = 1'b1; k++;
    end
    n = k;
    return s;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic send(input int d, input logic [8:0] data, input bit bad, input bit expect_word);
    logic [15:0] s;
    int n;
    exp_t e;
    s = build(d, data, bad, n);
    e.data = data & 9'((1 << cfg_db(d)) - 1);
    e.pe   = (cfg_par(d) != 0) && bad;
    e.fe   = 1'b0;
    e.bk   = 1'b0;
    if (expect_word) push_exp(d, e);
    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      rx[d] = s[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx[d] = 1'b1;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!rdy[d] && n < 600) begin
      @(negedge clk); n++;
    end
    check("ready_wait", rdy[d], 1'b1);
  endtask

  task automatic do_read(input int d);
    @(posedge clk); #1 rd[d] = 1'b1;
    @(posedge clk); #1 rd[d] = 1'b0;
    @(negedge clk);
    check("ready_after_read", rdy[d], 1'b0);
    check("overrun_after_read", ovr[d], 1'b0);
  endtask

  // Frame whose completion coincides with a one-cycle readData pulse.
  task automatic send_coincident(input int d, input logic [8:0] data);
    fork
      send(d, data, 1'b0, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (lat - 1) @(posedge clk);
        #1 rd[d] = 1'b1;
        @(posedge clk); #1 rd[d] = 1'b0;
      end
    join
  endtask

  task automatic reset_mid_frame(input int d, input logic [8:0] data);
    logic [15:0] s;
    int n;
    s = build(d, data, 1'b0, n);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      rx[d] = s[i];
      repeat (16) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rx[d] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", rdy[i], 1'b0);
      check("rst_data", dout[i], 9'h0);
      check("rst_flags", {perr[i], ferr[i], brk[i], ovr[i]}, 4'h0);
    end
  endtask

  // Monitor: a word is presented when ready rises, or when ready stays high
  // across a cycle in which readData was asserted (load coincident with read).
  logic [2:0] prev_rdy = 3'b000;
  logic [2:0] prev_rd  = 3'b000;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset && rdy[i] && (!prev_rdy[i] || prev_rd[i])) begin
        exp_t e;
        bit have = 1'b0;
        if (!prev_rdy[i]) rise_cyc[i] = cyc;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        check("word_expected", have, 1'b1);
        if (have) begin
          check("dataOut", dout[i], e.data);
          check("parityErr", perr[i], e.pe);
          check("frameErr", ferr[i], e.fe);
          check("breakDet", brk[i], e.bk);
        end
      end
    end
    prev_rdy = reset ? 3'b000 : rdy;
    prev_rd  = rd;
  end

  initial begin
    exp_t e;
    int seen;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", rdy[i], 1'b0);
      check("reset_data", dout[i], 9'h0);
      check("reset_flags", {perr[i], ferr[i], brk[i], ovr[i]}, 4'h0);
    end

    send(0, 9'hA5, 1'b0, 1'b1);
    wait_ready(0);
    lat = rise_cyc[0] - t0;
    check("latency_window", (lat >= 154) && (lat <= 160), 1'b1);
    check("overrun_clean", ovr[0], 1'b0);
    do_read(0);

    send(1, 9'h07, 1'b1, 1'b1);
    wait_ready(1);
    do_read(1);
    send(1, 9'h07, 1'b0, 1'b1);
    wait_ready(1);
    do_read(1);

    @(posedge clk); #1 rx[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx[0] = 1'b1;
    seen = 0;
    repeat (48) begin
      @(negedge clk);
      if (rdy[0]) seen = 1;
    end
    check("glitch_no_ready", seen, 0);
    send(0, 9'h3C, 1'b0, 1'b1);
    wait_ready(0);
    do_read(0);

    e.data = 9'h0; e.pe = 1'b0; e.fe = 1'b1; e.bk = 1'b1;
    push_exp(0, e);
    @(posedge clk); #1 rx[0] = 1'b0;
    repeat (160) @(posedge clk);
    #1 rx[0] = 1'b1;
    wait_ready(0);
    repeat (48) @(negedge clk);
    check("break_ready_held", rdy[0], 1'b1);
    do_read(0);

    send(0, 9'h11, 1'b0, 1'b1);
    send(0, 9'h22, 1'b0, 1'b0);
    @(negedge clk);
    check("ovr_set", ovr[0], 1'b1);
    check("ovr_keeps_word", dout[0], 9'h11);
    check("ovr_ready", rdy[0], 1'b1);
    do_read(0);
    send(0, 9'h11, 1'b0, 1'b1);
    send_coincident(0, 9'h22);
    @(negedge clk);
    check("coinc_ready", rdy[0], 1'b1);
    check("coinc_ovr_clear", ovr[0], 1'b0);
    check("coinc_data", dout[0], 9'h22);
    send(0, 9'h66, 1'b0, 1'b0);
    send_coincident(0, 9'h44);
    @(negedge clk);
    check("coinc_ovr_kept", ovr[0], 1'b1);
    check("coinc_data2", dout[0], 9'h44);

    reset_mid_frame(0, 9'h5A);
    send(0, 9'h5A, 1'b0, 1'b1);
    wait_ready(0);
    do_read(0);
    reset_mid_frame(2, 9'h15);
    send(2, 9'h15, 1'b0, 1'b1);
    wait_ready(2);
    do_read(2);

    for (int k = 0; k < 12; k++) begin
      int d;
      bit bad;
      d   = $urandom_range(0, 2);
      bad = (cfg_par(d) != 0) && ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      send(d, 9'($urandom), bad, 1'b1);
      wait_ready(d);
      do_read(d);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_empty", q0.size() + q1.size() + q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
